// File: rtl/m_imem_fetch.sv
// Fetch-side responder: direct-mapped one-word-per-line instruction cache.
// Ports: w_clk/w_rst_n clock and async active-low reset; w_pc fetch address;
//   w_flush invalidate-all pulse; w_ir/w_stall same-cycle instruction and stall;
//   r_mreq/r_maddr/w_mack/w_mdata refill handshake; r_nhit/r_nmiss saturating counters.
module m_imem_fetch #(
    parameter int unsigned IDX_W = 6,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic [31:0] w_pc,
    input  logic        w_flush,
    output logic [31:0] w_ir,
    output logic        w_stall,
    output logic        r_mreq,
    output logic [31:0] r_maddr,
    input  logic        w_mack,
    input  logic [31:0] w_mdata,
    output logic [31:0] r_nhit,
    output logic [31:0] r_nmiss
);
    localparam int unsigned LINES = 2 ** IDX_W;
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_e;

    state_e             state_q;
    logic [LINES-1:0]   valid_q;
    logic               flush_pend_q;
    logic [TAG_W-1:0]   tag_arr  [LINES];
    logic [31:0]        data_arr [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               fill_we;
    logic               unused_pc;

    assign idx       = w_pc[IDX_W+1:2];
    assign tag       = w_pc[31:IDX_W+2];
    assign fill_idx  = r_maddr[IDX_W+1:2];
    assign fill_tag  = r_maddr[31:IDX_W+2];
    assign unused_pc = ^w_pc[1:0];

    // A flush in the same cycle suppresses the hit so the core never
    // consumes a word from a line that is being invalidated.
    assign hit = (state_q == S_IDLE) & valid_q[idx]
               & (tag_arr[idx] == tag) & ~w_flush;

    assign w_stall = ~hit;
    assign w_ir    = hit ? data_arr[idx] : NOP;

    // The line is refilled from the latched address, not the live pc.
    assign fill_we = (state_q == S_REQ) & w_mack;

    // Data and tag storage carry no reset; valid bits gate their use.
    always_ff @(posedge w_clk) begin
        if (fill_we) begin
            data_arr[fill_idx] <= w_mdata;
            tag_arr[fill_idx]  <= fill_tag;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q      <= S_IDLE;
            r_mreq       <= 1'b0;
            r_maddr      <= '0;
            r_nhit       <= '0;
            r_nmiss      <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (hit && (r_nhit != 32'hFFFF_FFFF))
                r_nhit <= r_nhit + 32'd1;
            unique case (state_q)
                S_IDLE: begin
                    if (w_flush) begin
                        valid_q <= '0;
                    end else if (!hit) begin
                        state_q <= S_REQ;
                        r_mreq  <= 1'b1;
                        r_maddr <= {w_pc[31:2], 2'b00};
                        if (r_nmiss != 32'hFFFF_FFFF)
                            r_nmiss <= r_nmiss + 32'd1;
                    end
                end
                S_REQ: begin
                    if (w_mack) begin
                        state_q      <= S_IDLE;
                        r_mreq       <= 1'b0;
                        flush_pend_q <= 1'b0;
                        // A flush seen at any point of the refill
                        // also discards the line just written.
                        if (flush_pend_q || w_flush)
                            valid_q <= '0;
                        else
                            valid_q[fill_idx] <= 1'b1;
                    end else if (w_flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
